// File: rtl/rf_pkg.sv
// Shared types and helpers for the regfile_sb register file.
// Contents: rf_aw() address-width helper, addr_t/data_t typedefs at the default
// configuration, and REG_ZERO (the hard-wired zero register index).
package rf_pkg;

    // Address width for a register file of n entries (n is a power of two, >= 2).
    function automatic int unsigned rf_aw(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned AW_DEF       = rf_aw(NUM_REGS_DEF);

    typedef logic [AW_DEF-1:0]   addr_t;
    typedef logic [XLEN_DEF-1:0] data_t;

    localparam addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Write-pending scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   iss_req_i    an instruction with destination iss_addr_i was issued
//   iss_addr_i   destination register of the issued instruction
//   flush_i      clear every pending bit (overrides a same-cycle issue)
//   clr_i        one-hot-or-more vector of registers written back this cycle
//   pend_o       registered pending vector (bit 0 is always 0)
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned AW       = rf_aw(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_req_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                flush_i,
    input  logic [NUM_REGS-1:0] clr_i,
    output logic [NUM_REGS-1:0] pend_o
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_nxt;

    // Clear first so that a same-edge issue (newer producer) keeps the bit set;
    // flush overrides everything.
    always_comb begin
        w_pend_nxt = r_pend & ~clr_i;
        if (iss_req_i && (iss_addr_i != AW'(REG_ZERO))) begin
            w_pend_nxt[iss_addr_i] = 1'b1;
        end
        if (flush_i) begin
            w_pend_nxt = '0;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Pending state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign pend_o = r_pend;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a write-pending scoreboard.
// Build option: define RF_BYPASS_EN to forward same-cycle write data to reads.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   rd_addr_i    NUM_RD packed read addresses
//   rd_data_o    NUM_RD packed read data (combinational)
//   rd_ready_o   per-port operand valid (not pending, or bypassed)
//   wr_req_i     NUM_WR write strobes; higher port index wins on equal address
//   wr_addr_i    NUM_WR packed write addresses
//   wr_data_i    NUM_WR packed write data
//   iss_req_i    instruction issued with destination iss_addr_i
//   iss_addr_i   destination of the issued instruction
//   flush_i      clear all pending bits
//   pend_o       registered pending vector
module regfile_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*rf_aw(NUM_REGS)-1:0] rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]        rd_ready_o,
    input  logic [NUM_WR-1:0]        wr_req_i,
    input  logic [NUM_WR*rf_aw(NUM_REGS)-1:0] wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
    input  logic                     iss_req_i,
    input  logic [rf_aw(NUM_REGS)-1:0] iss_addr_i,
    input  logic                     flush_i,
    output logic [NUM_REGS-1:0]      pend_o
);

    localparam int unsigned AW = rf_aw(NUM_REGS);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_WR-1:0]   w_wr_act;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_pend;
    logic [NUM_RD*XLEN-1:0] w_rd_data;
    logic [NUM_RD-1:0]   w_rd_ready;

    // A write qualifies only when strobed and not targeting the zero register.
    always_comb begin
        w_wr_act = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            w_wr_act[w] = wr_req_i[w] && (wr_addr_i[w*AW +: AW] != AW'(REG_ZERO));
        end
    end

    // Registers receiving writeback this cycle release their pending bit.
    always_comb begin
        w_clr = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (w_wr_act[w]) begin
                w_clr[wr_addr_i[w*AW +: AW]] = 1'b1;
            end
        end
    end

    // Storage; later ports are applied last so the highest index wins.
    // Register 0 is never written and so always holds zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_act[w]) begin
                    r_regs[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_req_i  (iss_req_i),
        .iss_addr_i (iss_addr_i),
        .flush_i    (flush_i),
        .clr_i      (w_clr),
        .pend_o     (w_pend)
    );

    // Read muxes: stored value and scoreboard status, optionally overridden by
    // the highest-priority matching write of this cycle.
    always_comb begin
        w_rd_data  = '0;
        w_rd_ready = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_data[p*XLEN +: XLEN] = r_regs[rd_addr_i[p*AW +: AW]];
            w_rd_ready[p]             = ~w_pend[rd_addr_i[p*AW +: AW]];
`ifdef RF_BYPASS_EN
            // Writes presented during reset are discarded, so they never forward.
            for (int w = 0; w < NUM_WR; w++) begin
                if (rst_n && w_wr_act[w] &&
                    (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
                    w_rd_data[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
                    w_rd_ready[p]             = 1'b1;
                end
            end
`endif
            if (rd_addr_i[p*AW +: AW] == AW'(REG_ZERO)) begin
                w_rd_data[p*XLEN +: XLEN] = '0;
                w_rd_ready[p]             = 1'b1;
            end
        end
    end

    assign rd_data_o  = w_rd_data;
    assign rd_ready_o = w_rd_ready;
    assign pend_o     = w_pend;

endmodule
